// File: rtl/ir_queue.sv
// Instruction register with a DEPTH-entry prefetch FIFO for the 8-bit CPU datapath.
// State updates on the falling clock edge; outputs decode registered state only.
module ir_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             irload,
  input  logic             irnext,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;

  logic             wr_en;
  logic [PW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             is_full;
  logic             is_empty;
  logic             push_ok;
  logic             pop_ok;

  // Explicit wrap keeps DEPTH=1 (pointer stuck at 0) and non-power-of-two widths safe.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    wr_addr  = wr_ptr_q;
    wr_data  = din;
    push_ok  = 1'b0;
    pop_ok   = 1'b0;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      if (irload) begin
        wr_en    = 1'b1;
        wr_addr  = '0;
        wr_ptr_d = ptr_inc('0);
        count_d  = CW'(1);
      end
    end else begin
      // A full queue still accepts a push when the head leaves on the same edge.
      push_ok = irload && (!is_full || irnext);
      pop_ok  = irnext && !is_empty;

      if (irload && !push_ok) begin
        ovf_d = 1'b1;
      end

      if (push_ok) begin
        wr_en    = 1'b1;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end

      if (pop_ok) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end

      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: the storage array has no reset; stale words are masked by count on the output.
  always_ff @(negedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign dout     = is_empty ? '0 : mem_q[rd_ptr_q];
  assign valid    = !is_empty;
  assign empty    = is_empty;
  assign full     = is_full;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ir_queue.sv
// Self-checking bench for ir_queue: directed scenarios then random traffic,
// compared against a queue-based reference model.
module tb_ir_queue;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             irload;
  logic             irnext;
  logic             flush;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] mq[$];
  logic             movf;

  ir_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .irload   (irload),
    .irnext   (irnext),
    .flush    (flush),
    .dout     (dout),
    .valid    (valid),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: a pop frees space before a push on the same edge,
  // but a pop on an empty queue is ignored (no bypass).
  task automatic model_update(input logic l, input logic n, input logic f, input logic [WIDTH-1:0] d);
    if (f) begin
      mq.delete();
      movf = 1'b0;
      if (l) mq.push_back(d);
    end else begin
      if (n && mq.size() > 0) void'(mq.pop_front());
      if (l) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else movf = 1'b1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [WIDTH-1:0] exp_dout;
    exp_dout = (mq.size() > 0) ? mq[0] : '0;
    check({tag, ".dout"},     32'(dout),     32'(exp_dout));
    check({tag, ".count"},    32'(count),    32'(mq.size()));
    check({tag, ".valid"},    32'(valid),    32'(mq.size() != 0));
    check({tag, ".empty"},    32'(empty),    32'(mq.size() == 0));
    check({tag, ".full"},     32'(full),     32'(mq.size() == DEPTH));
    check({tag, ".overflow"}, 32'(overflow), 32'(movf));
  endtask

  // Drive on the rising edge, let the DUT update on the falling edge, sample 1 ns later.
  task automatic step(input string tag, input logic l, input logic n, input logic f,
                      input logic [WIDTH-1:0] d);
    @(posedge clk);
    irload = l;
    irnext = n;
    flush  = f;
    din    = d;
    @(negedge clk);
    model_update(l, n, f, d);
    #1;
    compare_all(tag);
  endtask

  initial begin
    rst    = 1'b0;
    din    = '0;
    irload = 1'b0;
    irnext = 1'b0;
    flush  = 1'b0;
    mq.delete();
    movf   = 1'b0;

    // Reset state
    #2;
    compare_all("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    // Reset and fill
    step("fill1", 1'b1, 1'b0, 1'b0, 8'h11);
    check("fill1_dout_lit", 32'(dout), 32'h11);
    step("fill2", 1'b1, 1'b0, 1'b0, 8'h22);
    step("fill3", 1'b1, 1'b0, 1'b0, 8'h33);
    check("fill3_count_lit", 32'(count), 32'd3);
    check("fill3_dout_lit",  32'(dout),  32'h11);
    step("clr1", 1'b0, 1'b0, 1'b1, 8'h00);

    // Overflow, then drain
    for (int i = 0; i < 5; i++) step("ovf_push", 1'b1, 1'b0, 1'b0, 8'hA1 + 8'(i));
    check("ovf_full_lit",  32'(full),     32'd1);
    check("ovf_flag_lit",  32'(overflow), 32'd1);
    check("ovf_count_lit", 32'(count),    32'd4);
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain_head", 32'(dout), 32'hA1 + 32'(i));
      step("ovf_pop", 1'b0, 1'b1, 1'b0, 8'h00);
    end
    check("ovf_drained_dout",  32'(dout),  32'd0);
    check("ovf_drained_empty", 32'(empty), 32'd1);
    step("clr2", 1'b0, 1'b0, 1'b1, 8'h00);

    // Full with simultaneous push/pop, then drain across the pointer wrap
    for (int i = 0; i < 4; i++) step("fpp_push", 1'b1, 1'b0, 1'b0, 8'hB0 + 8'(i));
    step("fpp_both", 1'b1, 1'b1, 1'b0, 8'hB4);
    check("fpp_count_lit", 32'(count),    32'd4);
    check("fpp_dout_lit",  32'(dout),     32'hB1);
    check("fpp_ovf_lit",   32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("fpp_drain_head", 32'(dout), 32'hB1 + 32'(i));
      step("fpp_pop", 1'b0, 1'b1, 1'b0, 8'h00);
    end

    // Empty with simultaneous push/pop, and pop on empty
    step("epp_both", 1'b1, 1'b1, 1'b0, 8'h5C);
    check("epp_count_lit", 32'(count), 32'd1);
    check("epp_dout_lit",  32'(dout),  32'h5C);
    step("epp_pop",   1'b0, 1'b1, 1'b0, 8'h00);
    step("epp_pop_e", 1'b0, 1'b1, 1'b0, 8'h00);
    check("epp_empty_count_lit", 32'(count), 32'd0);

    // Flush with push while holding 3 entries and overflow set
    for (int i = 0; i < 5; i++) step("fl_push", 1'b1, 1'b0, 1'b0, 8'hC0 + 8'(i));
    step("fl_pop", 1'b0, 1'b1, 1'b0, 8'h00);
    check("fl_pre_count_lit", 32'(count),    32'd3);
    check("fl_pre_ovf_lit",   32'(overflow), 32'd1);
    step("fl_flush", 1'b1, 1'b1, 1'b1, 8'h7E);
    check("fl_count_lit", 32'(count),    32'd1);
    check("fl_dout_lit",  32'(dout),     32'h7E);
    check("fl_ovf_lit",   32'(overflow), 32'd0);

    // Asynchronous reset mid-stream
    step("ar_push", 1'b1, 1'b0, 1'b0, 8'hD1);
    step("ar_idle", 1'b0, 1'b0, 1'b0, 8'h00);
    check("ar_pre_count_lit", 32'(count), 32'd2);
    @(posedge clk);
    #2 rst = 1'b0;
    mq.delete();
    movf = 1'b0;
    #1;
    compare_all("ar_async");
    check("ar_dout_lit", 32'(dout), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    step("ar_first", 1'b1, 1'b0, 1'b0, 8'h99);
    check("ar_first_dout_lit", 32'(dout), 32'h99);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic l, n, f;
      logic [WIDTH-1:0] d;
      l = ($urandom_range(0, 99) < 60);
      n = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 99) < 5);
      d = 8'($urandom);
      step("rand", l, n, f, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction register with prefetch buffering for the 8-bit CPU datapath. Instruction words arrive from the data register and are held in a DEPTH-entry FIFO, so memory can fetch ahead while the controller decodes the head entry. The controller consumes the head entry, and a branch or jump flushes all queued entries. With DEPTH=1 the block behaves like the single-word instruction register, except that it has an explicit consume input.

## Interface
- WIDTH, 8, instruction word width in bits.
- DEPTH, 4, number of queue entries; power of two, ≥ 1.
- CW, $clog2(DEPTH+1), width of the `count` output (derived).
- clk  in  1  system clock; all state updates on the **falling** edge.
- rst  in  1  asynchronous, active-low reset; 0 resets, 1 runs normally.
- din  in  WIDTH  instruction word from the data register.
- irload  in  1  push request: write `din` at the tail.
- irnext  in  1  pop request: discard the head entry.
- flush  in  1  discard all entries (branch/jump taken).
- dout  out  WIDTH  head entry; 0 when empty.
- valid  out  1  head entry present (equals `!empty`).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  CW  number of stored entries, 0..DEPTH.
- overflow  out  1  sticky flag: a push was dropped.

## Operation
- **Storage**
  - DEPTH × WIDTH register array.
  - Read and write pointers of $clog2(DEPTH) bits (1 bit when DEPTH=1).
  - Pointers wrap from DEPTH-1 to 0.
  - `count` register is CW bits.
- **Reset** (`rst`=0, asynchronous): pointers=0, count=0, overflow=0.
  - Outputs while in reset: dout=0, valid=0, empty=1, full=0.
  - Array contents need not be cleared.
- **Priority** per falling edge: reset > flush > push/pop.
- **Flush**
  - Pointers=0, count=0, overflow=0.
  - If `irload`=1 on the same edge, `din` is written to entry 0 and count=1.
  - `irnext` is ignored on a flush edge.
- **Push only** (`irload`=1, `irnext`=0)
  - If not full: write at the write pointer, advance it, count+1.
  - If full: word is dropped, state is unchanged, overflow set to 1.
- **Pop only** (`irload`=0, `irnext`=1)
  - If not empty: advance the read pointer, count-1.
  - If empty: ignored; no error flag.
- **Push and pop together**
  - Not empty, including full: write and read both occur; count unchanged; no overflow.
  - Empty: push occurs, pop is ignored, count=1. No bypass, so the pushed word is not consumed.
- **Outputs**
  - `dout` = array[read pointer] when count>0, otherwise 0.
  - `dout`, `valid`, `full`, `empty` and `count` are decoded combinationally from registered state only. No input-to-output combinational path.
- **Overflow**: stays at 1 until the next flush or reset.

## Timing
- **Push latency**: a word pushed into an empty queue at falling edge N appears on `dout`, with valid=1, immediately after edge N. The controller samples it at the following rising edge.
- **Pop latency**: after a pop at edge N, `dout` shows the next entry, or 0 if the queue is now empty, immediately after edge N.
- **Throughput**: one push and one pop per cycle sustained.
- **Input setup**: `irload`, `irnext`, `flush` and `din` are driven on the rising edge and must be stable at the falling edge.
- **Reset mid-operation**: asserting `rst` forces the reset values of all outputs immediately, without waiting for a clock edge. The first update after release occurs at the first falling edge with `rst`=1.
- **Wrap-around**: pointer wrap must not disturb `count`. Full versus empty is decided by `count`, never by pointer equality.

## Test plan
All scenarios use WIDTH=8 and DEPTH=4.
- **Reset and fill**
  - Stimulus: reset; push 0x11, 0x22, 0x33 on consecutive edges.
  - Required: count 1→2→3; dout=0x11 throughout; valid=1; full=0.
- **Overflow**
  - Stimulus: push 0xA1..0xA5 from empty, with no pops.
  - Required: count=4, full=1, overflow=1 after the 5th edge.
  - Then pop four times: dout sequence 0xA1, 0xA2, 0xA3, 0xA4, then 0x00 with empty=1.
- **Full with simultaneous push/pop**
  - Stimulus: queue full with 0xB0..0xB3; push 0xB4 and pop on the same edge.
  - Required: count=4, dout=0xB1, overflow=0.
  - Continue pops: order B1, B2, B3, B4, exercising pointer wrap.
- **Empty with simultaneous push/pop, and pop on empty**
  - Stimulus: push 0x5C and pop on the same edge into an empty queue.
  - Required: count=1, dout=0x5C.
  - A further pop on empty leaves count=0, dout=0, overflow unchanged.
- **Flush with push**
  - Stimulus: queue holds 3 entries with overflow=1; flush with `irload`=1, `din`=0x7E, `irnext`=1.
  - Required: count=1, dout=0x7E, overflow=0.
- **Asynchronous reset mid-stream**
  - Stimulus: drop `rst` midway between clock edges while the queue holds 2 entries.
  - Required: dout=0, count=0, empty=1 without any clock edge.
  - After release, the first push appears at the next falling edge.
